aluv_issue_ctl: RTL and testbench

- Sequencing front end that drives the team's 32-bit ALU (aluV_32) from the producer side of its ALUCtl/operand interface.
- Accepts one RV32 instruction plus register operands via valid/ready and decodes opcode/funct3/funct7 into ALUCtl.
- Drives registered operands into the ALU, captures result and flags, and presents them on a valid/ready output.
- Sits between the register-read stage and writeback/branch logic of the multi-cycle core.

---
 rtl/aluv_pkg.sv | 26 ++
 rtl/aluv_ctl_decode.sv | 95 +++++++++
 rtl/aluv_issue_ctl.sv | 152 +++++++++++++++
 tb/tb_aluv_issue_ctl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aluv_pkg.sv
// Shared constants for the ALU issue controller: ALUCtl codes, RV32 opcodes, FSM states.
// The optional branch evaluation is enabled with the ALUV_BRANCH_EVAL_EN macro.
package aluv_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/aluv_ctl_decode.sv
// Combinational RV32 decode into ALUCtl, operand B and legality.
// Branches (BEQ/BNE) are only legal when ALUV_BRANCH_EVAL_EN is defined.
module aluv_ctl_decode
    import aluv_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs2,
    output logic [3:0]  o_alu_ctl,
    output logic [31:0] o_alu_b,
    output logic        o_illegal,
    output logic        o_is_branch,
    output logic        o_branch_ne
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic        w_unused_fields;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_imm_i  = sext12(i_instr[31:20]);
    assign w_imm_s  = sext12({i_instr[31:25], i_instr[11:7]});
    // rs1 index is resolved upstream by the register-read stage
    assign w_unused_fields = ^i_instr[19:15];

    always_comb begin
        o_alu_ctl   = ALU_ADD;
        o_alu_b     = i_rs2;
        o_illegal   = 1'b1;
        o_is_branch = 1'b0;
        o_branch_ne = 1'b0;
        case (w_opcode)
            OP_R: begin
                case (w_funct3)
                    3'b000: begin
                        if (w_funct7 == 7'b0000000) begin
                            o_illegal = 1'b0;
                        end else if (w_funct7 == 7'b0100000) begin
                            o_alu_ctl = ALU_SUB;
                            o_illegal = 1'b0;
                        end
                    end
                    3'b111: begin
                        o_alu_ctl = ALU_AND;
                        o_illegal = 1'b0;
                    end
                    3'b110: begin
                        o_alu_ctl = ALU_OR;
                        o_illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                o_alu_b = w_imm_i;
                case (w_funct3)
                    3'b000: o_illegal = 1'b0;
                    3'b110: begin
                        o_alu_ctl = ALU_OR;
                        o_illegal = 1'b0;
                    end
                    3'b111: begin
                        o_alu_ctl = ALU_AND;
                        o_illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_LOAD: begin
                o_alu_b   = w_imm_i;
                o_illegal = 1'b0;
            end
            OP_STORE: begin
                o_alu_b   = w_imm_s;
                o_illegal = 1'b0;
            end
`ifdef ALUV_BRANCH_EVAL_EN
            OP_BRANCH: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b001) begin
                    o_alu_ctl   = ALU_SUB;
                    o_illegal   = 1'b0;
                    o_is_branch = 1'b1;
                    o_branch_ne = w_funct3[0];
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/aluv_issue_ctl.sv
// Issue controller feeding registered operands to aluV_32 and capturing its result.
// Optional BEQ/BNE evaluation on out_taken is enabled by defining ALUV_BRANCH_EVAL_EN.
module aluv_issue_ctl
    import aluv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    input  logic            alu_cout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_overflow,
    output logic            out_cout,
    output logic            out_taken,
    output logic            out_illegal
);

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_alu_a;
    logic [XLEN-1:0]   r_alu_b;
    logic [3:0]        r_alu_ctl;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;
    logic              r_overflow;
    logic              r_cout;
    logic              r_illegal;
    logic [3:0]        w_alu_ctl;
    logic [31:0]       w_alu_b;
    logic              w_illegal;
    logic              w_is_branch;
    logic              w_branch_ne;
    logic              w_accept;

    aluv_ctl_decode u_decode (
        .i_instr     (in_instr),
        .i_rs2       (in_rs2),
        .o_alu_ctl   (w_alu_ctl),
        .o_alu_b     (w_alu_b),
        .o_illegal   (w_illegal),
        .o_is_branch (w_is_branch),
        .o_branch_ne (w_branch_ne)
    );

    assign w_accept = (r_state == S_IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Illegal instructions skip EXEC since there is nothing for the ALU to compute.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = w_illegal ? S_DONE : S_EXEC;
            S_EXEC:  w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctl  <= ALU_AND;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_cout     <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            if (w_illegal) begin
                r_illegal  <= 1'b1;
                r_result   <= '0;
                r_zero     <= 1'b0;
                r_overflow <= 1'b0;
                r_cout     <= 1'b0;
            end else begin
                r_alu_a   <= in_rs1;
                r_alu_b   <= w_alu_b;
                r_alu_ctl <= w_alu_ctl;
                r_illegal <= 1'b0;
            end
        end else if (r_state == S_EXEC) begin
            r_result   <= alu_result;
            r_zero     <= alu_zero;
            r_overflow <= alu_overflow;
            r_cout     <= alu_cout;
        end
    end

`ifdef ALUV_BRANCH_EVAL_EN
    logic r_is_branch;
    logic r_branch_ne;
    logic r_taken;

    // Taken is the zero flag, inverted for BNE; non-branch ops always report not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_branch <= 1'b0;
            r_branch_ne <= 1'b0;
            r_taken     <= 1'b0;
        end else if (w_accept) begin
            if (w_illegal) begin
                r_taken <= 1'b0;
            end else begin
                r_is_branch <= w_is_branch;
                r_branch_ne <= w_branch_ne;
            end
        end else if (r_state == S_EXEC) begin
            r_taken <= r_is_branch & (alu_zero ^ r_branch_ne);
        end
    end

    assign out_taken = r_taken;
`else
    logic w_unused_branch;
    assign w_unused_branch = w_is_branch ^ w_branch_ne;
    assign out_taken       = 1'b0;
`endif

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_DONE);
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_ctl      = r_alu_ctl;
    assign out_result   = r_result;
    assign out_zero     = r_zero;
    assign out_overflow = r_overflow;
    assign out_cout     = r_cout;
    assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_aluv_issue_ctl.sv
// Self-checking bench for aluv_issue_ctl: directed vector table, hand sequences, and
// random instructions checked against an arithmetic reference model (honours ALUV_BRANCH_EVAL_EN).
module tb_aluv_issue_ctl;

    typedef enum {OPK_ADD, OPK_SUB, OPK_AND, OPK_OR} opk_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] res;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic        ill;
        logic        z;
        logic        v;
        logic        c;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic        ill;
        logic        z;
        logic        v;
        logic        c;
        logic        t;
        int          lat;
    } obs_t;

    typedef struct {
        opk_t        op;
        logic [31:0] res;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic        ill;
        logic        z;
        logic        v;
        logic        c;
        logic        t;
    } ref_t;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_cout;
    logic        out_taken;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    aluv_issue_ctl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctl      (alu_ctl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_cout     (alu_cout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_cout     (out_cout),
        .out_taken    (out_taken),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for aluV_32: subtraction done as a + ~b + 1, carry means no borrow.
    logic [31:0] aluBEff;
    logic [32:0] aluSum;
    always_comb begin
        aluBEff      = (alu_ctl == 4'b0110) ? ~alu_b : alu_b;
        aluSum       = {1'b0, alu_a} + {1'b0, aluBEff} + {32'b0, alu_ctl == 4'b0110};
        alu_result   = 32'h0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_ctl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010, 4'b0110: begin
                alu_result   = aluSum[31:0];
                alu_cout     = aluSum[32];
                alu_overflow = (alu_a[31] == aluBEff[31]) && (aluSum[31] != alu_a[31]);
            end
            default: ;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    function automatic ref_t refModel(input logic [31:0] instr, input logic [31:0] rs1,
                                      input logic [31:0] rs2);
        ref_t r;
        logic [6:0] opc = instr[6:0];
        logic [2:0] f3  = instr[14:12];
        logic [6:0] f7  = instr[31:25];
        logic signed [11:0] immI = instr[31:20];
        logic signed [11:0] immS = {instr[31:25], instr[11:7]};
        longint li;
        longint ua, ub, sa, sb, wide;
        bit isBr = 0;
        bit brNe = 0;
        r.op = OPK_ADD; r.res = 0; r.b = rs2; r.ctl = 4'b0010; r.ill = 1;
        r.z = 0; r.v = 0; r.c = 0; r.t = 0;
        if (opc == 7'b0110011) begin
            if (f3 == 3'b000 && f7 == 7'h00) r.ill = 0;
            else if (f3 == 3'b000 && f7 == 7'h20) begin r.ill = 0; r.op = OPK_SUB; end
            else if (f3 == 3'b111) begin r.ill = 0; r.op = OPK_AND; end
            else if (f3 == 3'b110) begin r.ill = 0; r.op = OPK_OR; end
        end else if (opc == 7'b0010011) begin
            li = immI; r.b = li[31:0];
            if (f3 == 3'b000) r.ill = 0;
            else if (f3 == 3'b110) begin r.ill = 0; r.op = OPK_OR; end
            else if (f3 == 3'b111) begin r.ill = 0; r.op = OPK_AND; end
        end else if (opc == 7'b0000011) begin
            li = immI; r.b = li[31:0]; r.ill = 0;
        end else if (opc == 7'b0100011) begin
            li = immS; r.b = li[31:0]; r.ill = 0;
        end
`ifdef ALUV_BRANCH_EVAL_EN
        else if (opc == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
            r.ill = 0; r.op = OPK_SUB; isBr = 1; brNe = (f3 == 3'b001);
        end
`endif
        if (r.ill) return r;
        ua = rs1; ub = r.b;
        sa = $signed(rs1); sb = $signed(r.b);
        case (r.op)
            OPK_ADD: begin
                wide = ua + ub; r.res = wide[31:0]; r.ctl = 4'b0010;
                r.c = (wide >= 64'sh1_0000_0000);
                r.v = (sa + sb > MAXS) || (sa + sb < MINS);
            end
            OPK_SUB: begin
                wide = ua - ub; r.res = wide[31:0]; r.ctl = 4'b0110;
                r.c = (ua >= ub);
                r.v = (sa - sb > MAXS) || (sa - sb < MINS);
            end
            OPK_AND: begin r.res = rs1 & r.b; r.ctl = 4'b0000; end
            OPK_OR:  begin r.res = rs1 | r.b; r.ctl = 4'b0001; end
            default: ;
        endcase
        r.z = (r.res == 32'h0);
        if (isBr) r.t = brNe ? (rs1 != rs2) : (rs1 == rs2);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Full handshake: wait for in_ready, present one instruction, wait for out_valid, sample, release.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rs1,
                                 input logic [31:0] rs2, output obs_t o);
        int waitCnt = 0;
        o.res = 0; o.b = 0; o.ctl = 0; o.ill = 0; o.z = 0; o.v = 0; o.c = 0; o.t = 0; o.lat = 0;
        while (!in_ready && waitCnt < 10) begin @(posedge clk); #1; waitCnt++; end
        if (!in_ready) begin checkOutput("in_ready_timeout", 32'(in_ready), 32'h1); return; end
        in_valid = 1'b1; in_instr = instr; in_rs1 = rs1; in_rs2 = rs2;
        @(posedge clk); #1;
        in_valid = 1'b0; in_instr = $urandom; in_rs1 = $urandom; in_rs2 = $urandom;
        o.lat = 1;
        while (!out_valid && o.lat < 8) begin @(posedge clk); #1; o.lat++; end
        if (!out_valid) begin checkOutput("out_valid_timeout", 32'(out_valid), 32'h1); return; end
        o.res = out_result; o.b = alu_b; o.ctl = alu_ctl; o.ill = out_illegal;
        o.z = out_zero; o.v = out_overflow; o.c = out_cout; o.t = out_taken;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] randVal();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] genInstr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 5))
            0: begin
                w[6:0] = 7'b0110011;
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    default: ;
                endcase
            end
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: begin w[6:0] = 7'b1100011; w[14:13] = ($urandom_range(0, 3) == 0) ? w[14:13] : 2'b00; end
            default: ;
        endcase
        return w;
    endfunction

    vec_t vecs[13];

    initial begin
        obs_t o;
        ref_t r;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] ins;

        vecs[0]  = '{instr:32'h002081B3, rs1:32'h7FFFFFFF, rs2:32'h1,        res:32'h80000000, b:32'h1,        ctl:4'b0010, ill:0, z:0, v:1, c:0};
        vecs[1]  = '{instr:32'h402081B3, rs1:32'h5,        rs2:32'h5,        res:32'h0,        b:32'h5,        ctl:4'b0110, ill:0, z:1, v:0, c:1};
        vecs[2]  = '{instr:32'hFFF08093, rs1:32'h0,        rs2:32'h1234,     res:32'hFFFFFFFF, b:32'hFFFFFFFF, ctl:4'b0010, ill:0, z:0, v:0, c:0};
        vecs[3]  = '{instr:32'h0F00E093, rs1:32'h0000000F, rs2:32'h5555,     res:32'h000000FF, b:32'h000000F0, ctl:4'b0001, ill:0, z:0, v:0, c:0};
        vecs[4]  = '{instr:32'h0000707F, rs1:32'h1,        rs2:32'h2,        res:32'h0,        b:32'h000000F0, ctl:4'b0001, ill:1, z:0, v:0, c:0};
        vecs[5]  = '{instr:32'h0020F1B3, rs1:32'hF0F01234, rs2:32'h0FF0FF00, res:32'h00F01200, b:32'h0FF0FF00, ctl:4'b0000, ill:0, z:0, v:0, c:0};
        vecs[6]  = '{instr:32'h0020E1B3, rs1:32'h0,        rs2:32'h0,        res:32'h0,        b:32'h0,        ctl:4'b0001, ill:0, z:1, v:0, c:0};
        vecs[7]  = '{instr:32'hFFC12183, rs1:32'h1000,     rs2:32'h77,       res:32'h00000FFC, b:32'hFFFFFFFC, ctl:4'b0010, ill:0, z:0, v:0, c:1};
        vecs[8]  = '{instr:32'h022081B3, rs1:32'h3,        rs2:32'h4,        res:32'h0,        b:32'hFFFFFFFC, ctl:4'b0010, ill:1, z:0, v:0, c:0};
        vecs[9]  = '{instr:32'h00512423, rs1:32'h100,      rs2:32'hDEAD,     res:32'h00000108, b:32'h8,        ctl:4'b0010, ill:0, z:0, v:0, c:0};
        vecs[10] = '{instr:32'hFE512FA3, rs1:32'h1,        rs2:32'hBEEF,     res:32'h0,        b:32'hFFFFFFFF, ctl:4'b0010, ill:0, z:1, v:0, c:1};
        vecs[11] = '{instr:32'h00109093, rs1:32'h9,        rs2:32'h9,        res:32'h0,        b:32'hFFFFFFFF, ctl:4'b0010, ill:1, z:0, v:0, c:0};
        vecs[12] = '{instr:32'h402081B3, rs1:32'h80000000, rs2:32'h1,        res:32'h7FFFFFFF, b:32'h1,        ctl:4'b0110, ill:0, z:0, v:1, c:1};

        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_rs1 = 32'h0; in_rs2 = 32'h0; out_ready = 1'b0;
        #12;
        checkOutput("rst.in_ready",  32'(in_ready),  32'h1);
        checkOutput("rst.out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst.alu_a",     alu_a,          32'h0);
        checkOutput("rst.alu_b",     alu_b,          32'h0);
        checkOutput("rst.alu_ctl",   32'(alu_ctl),   32'h0);
        checkOutput("rst.out_result", out_result,    32'h0);
        checkOutput("rst.flags", {28'h0, out_zero, out_overflow, out_cout, out_illegal}, 32'h0);
        checkOutput("rst.out_taken", 32'(out_taken), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // out_ready while idle must not create a result
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1; out_ready = 1'b0;
        checkOutput("idle_ready.out_valid", 32'(out_valid), 32'h0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, o);
            checkOutput($sformatf("v%0d.lat", i), 32'(o.lat), vecs[i].ill ? 32'h1 : 32'h2);
            checkOutput($sformatf("v%0d.res", i), o.res, vecs[i].res);
            checkOutput($sformatf("v%0d.b", i), o.b, vecs[i].b);
            checkOutput($sformatf("v%0d.ctl", i), 32'(o.ctl), 32'(vecs[i].ctl));
            checkOutput($sformatf("v%0d.ill_z_v_c_t", i), {27'h0, o.ill, o.z, o.v, o.c, o.t},
                        {27'h0, vecs[i].ill, vecs[i].z, vecs[i].v, vecs[i].c, 1'b0});
            checkOutput($sformatf("v%0d.released", i), {30'h0, out_valid, in_ready}, 32'h1);
        end

        // Backpressure: result held for 5 cycles, a pending instruction waits for IDLE
        in_valid = 1'b1; in_instr = 32'h402081B3; in_rs1 = 32'h9; in_rs2 = 32'h4;
        @(posedge clk); #1;
        in_instr = 32'h002081B3; in_rs1 = 32'h1; in_rs2 = 32'h2;
        @(posedge clk); #1;
        checkOutput("bp.first_valid", 32'(out_valid), 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp%0d.hold", k), {29'h0, out_valid, in_ready, out_cout}, 32'h5);
            checkOutput($sformatf("bp%0d.res", k), out_result, 32'h5);
            checkOutput($sformatf("bp%0d.ctl", k), 32'(alu_ctl), 32'h6);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp.idle", {30'h0, out_valid, in_ready}, 32'h1);
        checkOutput("bp.not_taken_yet", 32'(alu_ctl), 32'h6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("bp.second_valid", 32'(out_valid), 32'h1);
        checkOutput("bp.second_res", out_result, 32'h3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during EXEC discards the in-flight ADD at once
        in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1 = 32'h7FFFFFFF; in_rs2 = 32'h1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("mid.in_exec", {30'h0, out_valid, in_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid.rst_state", {30'h0, out_valid, in_ready}, 32'h1);
        checkOutput("mid.rst_alu_a", alu_a, 32'h0);
        checkOutput("mid.rst_ctl", 32'(alu_ctl), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid.after", {30'h0, out_valid, in_ready}, 32'h1);

        // Branch handling depends on the build option
`ifdef ALUV_BRANCH_EVAL_EN
        applyStimulus(32'h00208063, 32'h3, 32'h3, o);
        checkOutput("beq.taken", {29'h0, o.t, o.ill, o.z}, 32'h5);
        checkOutput("beq.ctl", 32'(o.ctl), 32'h6);
        checkOutput("beq.lat", 32'(o.lat), 32'h2);
        applyStimulus(32'h00209063, 32'h3, 32'h3, o);
        checkOutput("bne.taken", {29'h0, o.t, o.ill, o.z}, 32'h1);
`else
        applyStimulus(32'h00208063, 32'h3, 32'h3, o);
        checkOutput("beq.illegal", {30'h0, o.t, o.ill}, 32'h1);
        checkOutput("beq.lat", 32'(o.lat), 32'h1);
`endif

        for (int n = 0; n < 150; n++) begin
            ins = genInstr();
            rs1 = randVal();
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : randVal();
            r = refModel(ins, rs1, rs2);
            applyStimulus(ins, rs1, rs2, o);
            checkOutput($sformatf("rnd%0d.lat i=%08h", n, ins), 32'(o.lat), r.ill ? 32'h1 : 32'h2);
            checkOutput($sformatf("rnd%0d.res i=%08h", n, ins), o.res, r.res);
            checkOutput($sformatf("rnd%0d.ill_z_v_c_t i=%08h", n, ins), {27'h0, o.ill, o.z, o.v, o.c, o.t},
                        {27'h0, r.ill, r.z, r.v, r.c, r.t});
            if (!r.ill) begin
                checkOutput($sformatf("rnd%0d.b i=%08h", n, ins), o.b, r.b);
                checkOutput($sformatf("rnd%0d.ctl i=%08h", n, ins), 32'(o.ctl), 32'(r.ctl));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
